button_event_queue: RTL and testbench
=====================================

Name: button_event_queue

Overview:
- Consumes the 8-bit active-high button vector from the Genesis controller interface.
- Debounces each button and detects press and release edges.
- Generates auto-repeat events for the four D-pad directions.
- Queues coded events in a small FIFO, which the game/CPU side drains with a valid/ready handshake.

Parameters:
- DEBOUNCE_CYCLES, 256: consecutive sysclk cycles a raw bit must differ from its debounced value before the debounced value updates. Range 1..65535.
- REPEAT_DELAY, 2000000: sysclk cycles a D-pad bit must be held before its first repeat event. Must be ≥ REPEAT_PERIOD.
- REPEAT_PERIOD, 500000: sysclk cycles between subsequent repeat events. Must be ≥ 1.
- FIFO_DEPTH, 4: event FIFO entries. Power of 2, 2..16.

Ports:
- sysclk  in  1  system clock; all state changes on posedge.
- clr  in  1  synchronous, active-high reset.
- buttons  in  8  raw button state {Start,C,B,A,Right,Left,Down,Up}, 1 = pressed, synchronous to sysclk.
- held  out  8  debounced button state, same bit order.
- evt_valid  out  1  FIFO head entry valid.
- evt_ready  in  1  consumer accepts head entry this cycle.
- evt_code  out  5  {kind[1:0], idx[2:0]}; kind 00 = press, 01 = release, 10 = repeat, 11 = reserved (never emitted); idx = button bit index.
- overflow  out  1  sticky; an event was dropped.

Behaviour:
- Reset (clr = 1 at posedge): held = 0, all debounce/repeat counters = 0, all pending bits = 0, FIFO empty, evt_valid = 0, evt_code = 0, overflow = 0. Reset mid-operation discards queued and pending events.
- Debounce, per bit i, 16-bit counter:
  - If buttons[i] == held[i]: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: held[i] <= buttons[i], counter <= 0.
  - Else: counter++.
  - A glitch shorter than DEBOUNCE_CYCLES never changes held.
- Edge events: on the edge where held[i] changes 0→1, set press_pend[i]; on 1→0, set rel_pend[i] (release only if the macro below is defined).
- Repeat, bits 0..3 only, 24-bit counter per bit:
  - held[i] = 0: counter <= 0.
  - Else if counter == REPEAT_DELAY-1: set rep_pend[i], counter <= REPEAT_DELAY-REPEAT_PERIOD.
  - Else: counter++.
  - The first repeat occurs REPEAT_DELAY cycles after held rises; subsequent repeats occur every REPEAT_PERIOD cycles. Bits 4..7 never repeat.
- Pending overflow: if an event arrives for a pending bit that is already set, the event is dropped and overflow <= 1. overflow clears only on clr.
- Arbiter, at most one push per cycle:
  - Scan idx 0..7 ascending; within an index, priority is press > release > repeat.
  - The first pending bit found is pushed and cleared, provided a push is allowed.
  - A push is allowed when count < FIFO_DEPTH, or when count == FIFO_DEPTH and a pop occurs in the same cycle.
  - A pending bit set and selected in the same cycle is not allowed; a new pending bit is pushable from the next cycle.
- FIFO:
  - Pop when evt_valid & evt_ready.
  - evt_code is driven from the head register and is stable while evt_valid = 1 and evt_ready = 0.
  - evt_valid = (count != 0).
  - Simultaneous push and pop keeps count unchanged. Read/write pointers wrap modulo FIFO_DEPTH.
- Latency: with raw input stable from posedge k:
  - held updates at posedge k+DEBOUNCE_CYCLES-1.
  - Push occurs at k+DEBOUNCE_CYCLES if the FIFO is not full.
  - evt_valid is high after that edge.
- Pending bits persist while the FIFO is full; events are delayed, not lost, unless duplicated.

Optional Feature:
- Macro: BTN_RELEASE_EVT_EN.
- Defined: release events (kind 01) are generated as described above.
- Undefined: rel_pend logic is absent, kind 01 is never emitted, and held still falls normally.

Test Plan:
Benches override parameters to DEBOUNCE_CYCLES = 4, REPEAT_DELAY = 20, REPEAT_PERIOD = 8, FIFO_DEPTH = 4.
1. Reset then idle: buttons = 0x00 for 50 cycles, evt_ready = 1 → held = 0x00, evt_valid never 1, overflow = 0.
2. Debounce: buttons = 0x10 for 3 cycles then 0x00 → held stays 0x00, no event. Then buttons = 0x10 held steady → held = 0x10 after the 4th cycle; next cycle evt_valid = 1 with evt_code = 5'b00_100.
3. Simultaneous press and backpressure:
   - Stimulus: evt_ready = 0, buttons 0x00→0x81 steady.
   - Required: queue holds 0x00 (Up press) then 0x07 (Start press).
   - Then evt_ready = 1: pops in that order, one per cycle.
4. Auto-repeat: hold Left (0x04) with evt_ready = 1 → press 0x02. Then repeat 0x12 20 cycles after held rose, then again every 8 cycles. Release → repeats stop. Release event 0x0A is emitted if BTN_RELEASE_EVT_EN, otherwise no release event.
5. Full FIFO and overflow:
   - Stimulus: evt_ready = 0, produce 4 presses, then a 5th press, then release and re-press that 5th button before draining.
   - Required: count = 4, evt_valid = 1, overflow = 1, head unchanged.
   - After evt_ready = 1: five events drain.
6. Reset mid-operation: assert clr with 3 queued entries and held = 0x0F → next cycle evt_valid = 0, held = 0x00, overflow = 0.

Source files
------------

// File: rtl/button_event_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : button_event_queue                                              |
// | Purpose  : Debounces the 8 controller buttons, raises press/repeat events  |
// |            (release events when BTN_RELEASE_EVT_EN is defined) and queues  |
// |            them in a small FIFO drained with a valid/ready handshake.      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module button_event_queue #(
  parameter int DEBOUNCE_CYCLES = 256,
  parameter int REPEAT_DELAY    = 2000000,
  parameter int REPEAT_PERIOD   = 500000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic       sysclk,
  input  logic       clr,
  input  logic [7:0] buttons,
  output logic [7:0] held,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [4:0] evt_code,
  output logic       overflow
);

  localparam int          c_ptr_w      = $clog2(FIFO_DEPTH);
  localparam logic [15:0] c_db_max     = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] c_rep_max    = 24'(REPEAT_DELAY - 1);
  localparam logic [23:0] c_rep_reload = 24'(REPEAT_DELAY - REPEAT_PERIOD);
  localparam logic [c_ptr_w:0] c_depth = (c_ptr_w + 1)'(FIFO_DEPTH);

  logic [7:0] r_held;
  logic [7:0] w_db_fire;
  logic [7:0] w_rise;
  logic [3:0] w_rep_fire;
  logic [7:0] r_press_pend;
  logic [3:0] r_rep_pend;
  logic [7:0] w_rep_pend8;
  logic       r_overflow;
  logic       w_rel_ovf;

  logic       w_sel_found;
  logic [4:0] w_sel_code;
  logic [7:0] w_sel_press;
  logic [3:0] w_sel_rep;
  logic       w_push;
  logic       w_pop;

  logic [4:0]         r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;

  // A bit flips only after it has disagreed with held for DEBOUNCE_CYCLES samples.
  for (genvar gi = 0; gi < 8; gi++) begin : g_db
    logic [15:0] r_cnt;
    assign w_db_fire[gi] = (buttons[gi] != r_held[gi]) && (r_cnt == c_db_max);
    always_ff @(posedge sysclk) begin
      if (clr || (buttons[gi] == r_held[gi]) || w_db_fire[gi]) r_cnt <= '0;
      else                                                      r_cnt <= r_cnt + 16'd1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (clr) r_held <= '0;
    else     r_held <= r_held ^ w_db_fire;
  end

  assign w_rise = w_db_fire & buttons;

  for (genvar gi = 0; gi < 4; gi++) begin : g_rep
    logic [23:0] r_cnt;
    assign w_rep_fire[gi] = r_held[gi] && (r_cnt == c_rep_max);
    always_ff @(posedge sysclk) begin
      if (clr || !r_held[gi]) r_cnt <= '0;
      else if (w_rep_fire[gi]) r_cnt <= c_rep_reload;
      else                     r_cnt <= r_cnt + 24'd1;
    end
  end

  assign w_rep_pend8 = {4'b0000, r_rep_pend};

`ifdef BTN_RELEASE_EVT_EN
  logic [7:0] r_rel_pend;
  logic [7:0] w_sel_rel;
  logic [7:0] w_fall;
  assign w_fall    = w_db_fire & ~buttons;
  assign w_rel_ovf = |(w_fall & r_rel_pend);
  always_ff @(posedge sysclk) begin
    if (clr) r_rel_pend <= '0;
    else     r_rel_pend <= (r_rel_pend & ~(w_sel_rel & {8{w_push}})) | (w_fall & ~r_rel_pend);
  end
`else
  assign w_rel_ovf = 1'b0;
`endif

  // Lowest index wins; within an index press beats release beats repeat.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_code  = '0;
    w_sel_press = '0;
    w_sel_rep   = '0;
`ifdef BTN_RELEASE_EVT_EN
    w_sel_rel   = '0;
`endif
    for (int i = 0; i < 8; i++) begin
      if (!w_sel_found && r_press_pend[i]) begin
        w_sel_found    = 1'b1;
        w_sel_code     = {2'b00, 3'(i)};
        w_sel_press[i] = 1'b1;
      end
`ifdef BTN_RELEASE_EVT_EN
      if (!w_sel_found && r_rel_pend[i]) begin
        w_sel_found  = 1'b1;
        w_sel_code   = {2'b01, 3'(i)};
        w_sel_rel[i] = 1'b1;
      end
`endif
      if (!w_sel_found && w_rep_pend8[i]) begin
        w_sel_found = 1'b1;
        w_sel_code  = {2'b10, 3'(i)};
        w_sel_rep   = 4'(1 << i);
      end
    end
  end

  assign w_pop  = evt_valid && evt_ready;
  assign w_push = w_sel_found && ((r_count < c_depth) || w_pop);

  // An event landing on an already-pending bit is dropped, not merged.
  always_ff @(posedge sysclk) begin
    if (clr) begin
      r_press_pend <= '0;
      r_rep_pend   <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_press_pend <= (r_press_pend & ~(w_sel_press & {8{w_push}})) | (w_rise & ~r_press_pend);
      r_rep_pend   <= (r_rep_pend & ~(w_sel_rep & {4{w_push}})) | (w_rep_fire & ~r_rep_pend);
      if ((|(w_rise & r_press_pend)) || (|(w_rep_fire & r_rep_pend)) || w_rel_ovf)
        r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (clr) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_sel_code;
        r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  assign held      = r_held;
  assign evt_valid = (r_count != '0);
  assign evt_code  = r_mem[r_rd_ptr];
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_button_event_queue.sv
`default_nettype none
// Scoreboard bench for button_event_queue: stimulus queues expected codes,
// a negedge monitor pops and compares every accepted event.
module tb_button_event_queue;

  logic       sysclk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] buttons = 8'h00;
  logic       evt_ready = 1'b0;
  logic [7:0] held;
  logic       evt_valid;
  logic [4:0] evt_code;
  logic       overflow;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [4:0] exp_q[$];
  int pop_cyc[$];

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  button_event_queue #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8),
    .FIFO_DEPTH     (4)
  ) dut (
    .sysclk   (sysclk),
    .clr      (clr),
    .buttons  (buttons),
    .held     (held),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_code (evt_code),
    .overflow (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake that will complete at the next edge is scored.
  always @(negedge sysclk) begin
    if (!clr && evt_valid && evt_ready) begin
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got 0x%0h expected none", evt_code);
      end else begin
        check("event_code", {27'd0, evt_code}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic expect_evt(input logic [4:0] code);
    exp_q.push_back(code);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge sysclk);
      n++;
    end
    check(name, exp_q.size(), 0);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int exp_cyc[5];

    // Reset state
    tick(3);
    @(negedge sysclk);
    check("rst_held", held, 8'h00);
    check("rst_valid", evt_valid, 1'b0);
    check("rst_code", evt_code, 5'h00);
    check("rst_overflow", overflow, 1'b0);
    tick(1);
    clr = 1'b0;
    evt_ready = 1'b1;

    // 1. idle
    tick(50);
    @(negedge sysclk);
    check("idle_held", held, 8'h00);
    check("idle_valid", evt_valid, 1'b0);
    check("idle_overflow", overflow, 1'b0);

    // 2. glitch of DEBOUNCE_CYCLES-1 samples is ignored, then latency of a real press
    tick(1);
    buttons = 8'h10;
    tick(3);
    buttons = 8'h00;
    tick(6);
    @(negedge sysclk);
    check("glitch_held", held, 8'h00);
    check("glitch_valid", evt_valid, 1'b0);
    tick(1);
    expect_evt(5'b00_100);
    buttons = 8'h10;
    repeat (4) @(posedge sysclk);
    @(negedge sysclk);
    check("db_held", held, 8'h10);
    check("db_valid_early", evt_valid, 1'b0);
    @(posedge sysclk);
    @(negedge sysclk);
    check("db_valid", evt_valid, 1'b1);
    check("db_code", evt_code, 5'b00_100);
    tick(1);
`ifdef BTN_RELEASE_EVT_EN
    expect_evt(5'b01_100);
`endif
    buttons = 8'h00;
    tick(8);
    wait_drain("t2_drained");

    // 3. simultaneous press under backpressure
    evt_ready = 1'b0;
    expect_evt(5'h00);
    expect_evt(5'h07);
    buttons = 8'h81;
    tick(8);
    @(negedge sysclk);
    check("bp_valid", evt_valid, 1'b1);
    check("bp_head", evt_code, 5'h00);
    tick(1);
    evt_ready = 1'b1;
    tick(3);
`ifdef BTN_RELEASE_EVT_EN
    expect_evt(5'h08);
    expect_evt(5'h0F);
`endif
    buttons = 8'h00;
    tick(8);
    wait_drain("t3_drained");

    // 4. auto-repeat on Left with timing of each pop
    pop_cyc.delete();
    expect_evt(5'h02);
    expect_evt(5'h12);
    expect_evt(5'h12);
    expect_evt(5'h12);
`ifdef BTN_RELEASE_EVT_EN
    expect_evt(5'h0A);
`endif
    buttons = 8'h04;
    c0 = cyc;
    tick(40);
    buttons = 8'h00;
    tick(40);
    wait_drain("t4_drained");
    exp_cyc[0] = c0 + 5;
    exp_cyc[1] = c0 + 25;
    exp_cyc[2] = c0 + 33;
    exp_cyc[3] = c0 + 41;
    exp_cyc[4] = c0 + 45;
`ifdef BTN_RELEASE_EVT_EN
    check("t4_pop_count", pop_cyc.size(), 5);
`else
    check("t4_pop_count", pop_cyc.size(), 4);
`endif
    for (int i = 0; i < pop_cyc.size() && i < 5; i++)
      check($sformatf("t4_pop_cycle_%0d", i), pop_cyc[i], exp_cyc[i]);
    check("t4_overflow", overflow, 1'b0);

    // 5. full FIFO, pending 5th press, duplicate press overflows
    evt_ready = 1'b0;
    expect_evt(5'h04);
    expect_evt(5'h05);
    expect_evt(5'h06);
    expect_evt(5'h07);
    expect_evt(5'h00);
`ifdef BTN_RELEASE_EVT_EN
    expect_evt(5'h08);
`endif
    buttons = 8'hF0;
    tick(12);
    buttons = 8'hF1;
    tick(8);
    @(negedge sysclk);
    check("full_no_overflow", overflow, 1'b0);
    tick(1);
    buttons = 8'hF0;
    tick(8);
    buttons = 8'hF1;
    tick(8);
    @(negedge sysclk);
    check("full_valid", evt_valid, 1'b1);
    check("full_overflow", overflow, 1'b1);
    check("full_head", evt_code, 5'h04);
    check("full_held", held, 8'hF1);
    tick(1);
    evt_ready = 1'b1;
    tick(8);
`ifdef BTN_RELEASE_EVT_EN
    expect_evt(5'h08);
    expect_evt(5'h0C);
    expect_evt(5'h0D);
    expect_evt(5'h0E);
    expect_evt(5'h0F);
`endif
    buttons = 8'h00;
    tick(8);
    wait_drain("t5_drained");
    check("t5_overflow_sticky", overflow, 1'b1);

    // 6. reset with three queued entries and held = 0x0F
    evt_ready = 1'b0;
    buttons = 8'h0F;
    tick(7);
    check("pre_rst_held", held, 8'h0F);
    check("pre_rst_valid", evt_valid, 1'b1);
    clr = 1'b1;
    buttons = 8'h00;
    @(posedge sysclk);
    @(negedge sysclk);
    check("mid_rst_valid", evt_valid, 1'b0);
    check("mid_rst_held", held, 8'h00);
    check("mid_rst_overflow", overflow, 1'b0);
    check("mid_rst_code", evt_code, 5'h00);
    tick(1);
    clr = 1'b0;
    evt_ready = 1'b1;
    tick(30);
    @(negedge sysclk);
    check("post_rst_valid", evt_valid, 1'b0);
    check("post_rst_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
